// File: rtl/gayle_sector_xfer.sv
// ATA PIO data-phase sequencer: CPU data strokes -> FIFO strobes, word/sector/block counting, BSY/DRQ/IRQ.
// Optional GAYLE_XFER_MULTIPLE_EN honours cmd_blk (READ/WRITE MULTIPLE); otherwise each sector is a block.
module gayle_sector_xfer #(
  parameter int WORDS_PER_SECTOR = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       cmd_start,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_sectors,
  input  logic [4:0] cmd_blk,
  input  logic       cmd_abort,
  input  logic       data_rd,
  input  logic       data_wr,
  input  logic       irq_ack,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       fifo_wr,
  output logic       hps_req,
  output logic       bsy,
  output logic       drq,
  output logic       irq,
  output logic       xfer_active
);
  typedef enum logic [2:0] {IDLE, R_WAIT, R_XFER, W_XFER, W_WAIT} state_t;
  localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_SECTOR - 1);

  state_t     state, state_nxt;
  logic [7:0] words;
  logic [8:0] sect_left, sect_dec;
  logic [4:0] blk_left, blk_dec, blk_size, cmd_blk_eff;
  logic       start, rd_acc, wr_acc, stroke, sect_end, blk_first, irq_set;
  logic       drq_nxt, bsy_nxt;

`ifdef GAYLE_XFER_MULTIPLE_EN
  assign cmd_blk_eff = (cmd_blk == 5'd0) ? 5'd1 : cmd_blk;
`else
  logic unused_cmd_blk;
  assign unused_cmd_blk = ^cmd_blk;
  assign cmd_blk_eff    = 5'd1;
`endif

  assign start    = cmd_start & ~cmd_abort & (state == IDLE);
  assign rd_acc   = clk7_en & data_rd & drq & ~cmd_abort & (state == R_XFER);
  assign wr_acc   = clk7_en & data_wr & drq & ~cmd_abort & (state == W_XFER);
  assign stroke   = rd_acc | wr_acc;
  assign sect_end = stroke & (words == LAST_WORD);
  assign sect_dec = sect_left - 9'd1;
  assign blk_dec  = blk_left - 5'd1;
  // blk_left is 0 after a finished block and equals blk_size right after cmd_start
  assign blk_first = (blk_left == 5'd0) || (blk_left == blk_size);
  assign irq_set   = ~cmd_abort & (((state == R_WAIT) & fifo_full & blk_first) |
                                   ((state == W_WAIT) & fifo_empty));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      drq     <= 1'b0;
      bsy     <= 1'b0;
      hps_req <= 1'b0;
    end else begin
      state   <= state_nxt;
      drq     <= drq_nxt;
      bsy     <= bsy_nxt;
      hps_req <= ~cmd_abort & ((state == R_WAIT) | (state == W_WAIT));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cmd_start) state_nxt = cmd_dir ? R_WAIT : W_XFER;
      R_WAIT: if (fifo_full) state_nxt = R_XFER;
      R_XFER: if (sect_end) begin
        if (sect_dec == 9'd0)                   state_nxt = IDLE;
        else if (fifo_full && blk_dec != 5'd0)  state_nxt = R_XFER;
        else                                    state_nxt = R_WAIT;
      end
      W_XFER: if (sect_end && (blk_dec == 5'd0 || sect_dec == 9'd0)) state_nxt = W_WAIT;
      W_WAIT: if (fifo_empty) state_nxt = (sect_left == 9'd0) ? IDLE : W_XFER;
      default: state_nxt = IDLE;
    endcase
    if (cmd_abort) state_nxt = IDLE;
  end

  always_comb begin
    fifo_rd     = rd_acc;
    fifo_wr     = wr_acc;
    xfer_active = (state != IDLE);
    drq_nxt     = (state_nxt == R_XFER) || (state_nxt == W_XFER);
    bsy_nxt     = (state_nxt == R_WAIT) || (state_nxt == W_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words     <= 8'd0;
      sect_left <= 9'd0;
      blk_left  <= 5'd0;
      blk_size  <= 5'd0;
      irq       <= 1'b0;
    end else begin
      if (irq_set)               irq <= 1'b1;
      else if (irq_ack | start)  irq <= 1'b0;

      if (start) begin
        words     <= 8'd0;
        sect_left <= {cmd_sectors == 8'd0, cmd_sectors};
        blk_size  <= cmd_blk_eff;
        blk_left  <= cmd_blk_eff;
      end else if (!cmd_abort) begin
        if (stroke)   words <= sect_end ? 8'd0 : words + 8'd1;
        if (sect_end) begin
          sect_left <= sect_dec;
          blk_left  <= blk_dec;
        end
        // new block begins: read resumes after a block-ending wait, write resumes after drain
        if (state == R_WAIT && fifo_full && blk_left == 5'd0)    blk_left <= blk_size;
        if (state == W_WAIT && fifo_empty && sect_left != 9'd0)  blk_left <= blk_size;
      end
    end
  end
endmodule

// File: tb/tb_gayle_sector_xfer.sv
// Scoreboarded bench for gayle_sector_xfer with a short sector size to keep the 256-sector run brief.
module tb_gayle_sector_xfer;
  localparam int WPS = 64;
`ifdef GAYLE_XFER_MULTIPLE_EN
  localparam int MULT = 1;
`else
  localparam int MULT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, clk7_en, cmd_start, cmd_dir, cmd_abort;
  logic [7:0] cmd_sectors;
  logic [4:0] cmd_blk;
  logic       data_rd, data_wr, irq_ack, fifo_full, fifo_empty;
  logic       fifo_rd, fifo_wr, hps_req, bsy, drq, irq, xfer_active;
  logic [6:0] outs;

  int n_cmp = 0;
  int n_err = 0;
  int sb_q[$];

  assign outs = {fifo_rd, fifo_wr, hps_req, bsy, drq, irq, xfer_active};

  always #5 clk = ~clk;

  gayle_sector_xfer #(.WORDS_PER_SECTOR(WPS)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .cmd_start(cmd_start), .cmd_dir(cmd_dir),
    .cmd_sectors(cmd_sectors), .cmd_blk(cmd_blk), .cmd_abort(cmd_abort), .data_rd(data_rd),
    .data_wr(data_wr), .irq_ack(irq_ack), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .hps_req(hps_req), .bsy(bsy), .drq(drq), .irq(irq),
    .xfer_active(xfer_active)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input logic dir, input logic [7:0] secs, input logic [4:0] blk);
    cmd_start = 1'b1; cmd_dir = dir; cmd_sectors = secs; cmd_blk = blk;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    int exp;
    sb_q.push_back(0);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if (outs !== 7'(exp)) begin n_err++; $display("FAIL reset_state: got %b want %b", outs, 7'(exp)); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_one();
    int exp;
    start_cmd(1'b1, 8'd1, 5'd0);
    tick();
    // fifo_rd fifo_wr hps_req bsy drq irq xfer_active
    sb_q.push_back(7'b0011001);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if (outs !== 7'(exp)) begin n_err++; $display("FAIL read_one_wait: got %b want %b", outs, 7'(exp)); end
    tick();
    fifo_full = 1'b1;
    tick();
    sb_q.push_back(3'b110);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if ({drq, irq, bsy} !== 3'(exp)) begin n_err++; $display("FAIL read_one_xfer drq/irq/bsy: got %b want %b", {drq, irq, bsy}, 3'(exp)); end
    tick();
    data_rd = 1'b1;
    for (int i = 0; i <= WPS; i++) begin
      sb_q.push_back(i < WPS);
      @(negedge clk);
      exp = sb_q.pop_front(); n_cmp++;
      if (fifo_rd !== exp[0]) begin n_err++; $display("FAIL read_one_strobe %0d: got %b want %b", i, fifo_rd, exp[0]); end
      tick();
    end
    data_rd = 1'b0; fifo_full = 1'b0;
    sb_q.push_back(2'b00);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if ({drq, xfer_active} !== 2'(exp)) begin n_err++; $display("FAIL read_one_end drq/active: got %b want %b", {drq, xfer_active}, 2'(exp)); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    sb_q.push_back(0);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if (irq !== exp[0]) begin n_err++; $display("FAIL read_one_irq_ack: got %b want %b", irq, exp[0]); end
    tick();
  endtask

  task automatic test_read_all();
    int exp, rd_cnt, sets, cyc;
    logic irq_d;
    rd_cnt = 0; sets = 0; cyc = 0; irq_d = 1'b0;
    start_cmd(1'b1, 8'd0, 5'd0);
    fifo_full = 1'b1; data_rd = 1'b1;
    sb_q.push_back(WPS * 256);
    sb_q.push_back(256);
    sb_q.push_back(0);
    while (cyc < 256 * (WPS + 2) + 64) begin
      @(negedge clk);
      if (fifo_rd) rd_cnt++;
      if (irq && !irq_d) sets++;
      irq_d = irq;
      irq_ack = irq;
      if (!xfer_active) break;
      tick();
      cyc++;
    end
    data_rd = 1'b0; fifo_full = 1'b0; irq_ack = 1'b0;
    exp = sb_q.pop_front(); n_cmp++;
    if (rd_cnt !== exp) begin n_err++; $display("FAIL read_all_words: got %0d want %0d", rd_cnt, exp); end
    exp = sb_q.pop_front(); n_cmp++;
    if (sets !== exp) begin n_err++; $display("FAIL read_all_irqs: got %0d want %0d", sets, exp); end
    exp = sb_q.pop_front(); n_cmp++;
    if (xfer_active !== exp[0]) begin n_err++; $display("FAIL read_all_done (cycle budget): got %b want %b", xfer_active, exp[0]); end
    tick();
  endtask

  task automatic test_write();
    int exp, nblk, spb;
    logic last;
    nblk = (MULT != 0) ? 1 : 2;
    spb  = (MULT != 0) ? 2 : 1;
    start_cmd(1'b0, 8'd2, 5'd2);
    sb_q.push_back(4'b1001);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if ({drq, bsy, irq, xfer_active} !== 4'(exp)) begin n_err++; $display("FAIL write_start drq/bsy/irq/active: got %b want %b", {drq, bsy, irq, xfer_active}, 4'(exp)); end
    tick();
    for (int b = 0; b < nblk; b++) begin
      last = (b == nblk - 1);
      data_wr = 1'b1;
      for (int i = 0; i < spb * WPS; i++) begin
        sb_q.push_back(1);
        @(negedge clk);
        exp = sb_q.pop_front(); n_cmp++;
        if (fifo_wr !== exp[0]) begin n_err++; $display("FAIL write_strobe b%0d w%0d: got %b want %b", b, i, fifo_wr, exp[0]); end
        tick();
      end
      data_wr = 1'b0;
      sb_q.push_back(3'b010);
      @(negedge clk);
      exp = sb_q.pop_front(); n_cmp++;
      if ({drq, bsy, irq} !== 3'(exp)) begin n_err++; $display("FAIL write_wait b%0d drq/bsy/irq: got %b want %b", b, {drq, bsy, irq}, 3'(exp)); end
      tick();
      sb_q.push_back(1);
      @(negedge clk);
      exp = sb_q.pop_front(); n_cmp++;
      if (hps_req !== exp[0]) begin n_err++; $display("FAIL write_hps_req b%0d: got %b want %b", b, hps_req, exp[0]); end
      tick();
      fifo_empty = 1'b1; tick(); fifo_empty = 1'b0;
      sb_q.push_back({1'b1, 1'b0, ~last, ~last});
      @(negedge clk);
      exp = sb_q.pop_front(); n_cmp++;
      if ({irq, bsy, drq, xfer_active} !== 4'(exp)) begin n_err++; $display("FAIL write_drain b%0d irq/bsy/drq/active: got %b want %b", b, {irq, bsy, drq, xfer_active}, 4'(exp)); end
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    end
    tick();
  endtask

  task automatic test_gating();
    int exp, cnt;
    cnt = 0;
    start_cmd(1'b1, 8'd1, 5'd0);
    data_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(0);
      @(negedge clk);
      exp = sb_q.pop_front(); n_cmp++;
      if (fifo_rd !== exp[0]) begin n_err++; $display("FAIL gate_no_drq %0d: got %b want %b", i, fifo_rd, exp[0]); end
      tick();
    end
    data_rd = 1'b0; fifo_full = 1'b1;
    tick();
    clk7_en = 1'b0; data_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(0);
      @(negedge clk);
      exp = sb_q.pop_front(); n_cmp++;
      if (fifo_rd !== exp[0]) begin n_err++; $display("FAIL gate_clk7 %0d: got %b want %b", i, fifo_rd, exp[0]); end
      tick();
    end
    clk7_en = 1'b1;
    sb_q.push_back(WPS);
    for (int i = 0; i < 2 * WPS; i++) begin
      @(negedge clk);
      if (fifo_rd) cnt++;
      if (!drq) break;
      tick();
    end
    data_rd = 1'b0; fifo_full = 1'b0;
    exp = sb_q.pop_front(); n_cmp++;
    if (cnt !== exp) begin n_err++; $display("FAIL gate_word_count: got %0d want %0d", cnt, exp); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int exp;
    start_cmd(1'b1, 8'd2, 5'd0);
    fifo_full = 1'b1;
    tick();
    data_rd = 1'b1;
    repeat (40) tick();
    cmd_abort = 1'b1; data_rd = 1'b0;
    tick();
    cmd_abort = 1'b0; fifo_full = 1'b0;
    // drq bsy hps_req xfer_active irq
    sb_q.push_back(5'b00001);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if ({drq, bsy, hps_req, xfer_active, irq} !== 5'(exp)) begin n_err++; $display("FAIL abort_outputs: got %b want %b", {drq, bsy, hps_req, xfer_active, irq}, 5'(exp)); end
    tick();
    cmd_abort = 1'b1;
    start_cmd(1'b0, 8'd1, 5'd0);
    cmd_abort = 1'b0;
    sb_q.push_back(3'b001);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if ({xfer_active, drq, irq} !== 3'(exp)) begin n_err++; $display("FAIL abort_with_start: got %b want %b", {xfer_active, drq, irq}, 3'(exp)); end
    tick();
    start_cmd(1'b0, 8'd1, 5'd0);
    sb_q.push_back(3'b110);
    @(negedge clk);
    exp = sb_q.pop_front(); n_cmp++;
    if ({xfer_active, drq, irq} !== 3'(exp)) begin n_err++; $display("FAIL restart_after_abort: got %b want %b", {xfer_active, drq, irq}, 3'(exp)); end
    tick();
  endtask

  task automatic test_async_reset();
    int exp;
    data_wr = 1'b1;
    repeat (5) tick();
    #2;
    sb_q.push_back(1);
    exp = sb_q.pop_front(); n_cmp++;
    if (fifo_wr !== exp[0]) begin n_err++; $display("FAIL pre_reset_fifo_wr: got %b want %b", fifo_wr, exp[0]); end
    sb_q.push_back(0);
    reset = 1'b1;
    #1;
    exp = sb_q.pop_front(); n_cmp++;
    if (outs !== 7'(exp)) begin n_err++; $display("FAIL async_reset: got %b want %b", outs, 7'(exp)); end
    data_wr = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; clk7_en = 1'b1; cmd_start = 1'b0; cmd_dir = 1'b0; cmd_sectors = 8'd0;
    cmd_blk = 5'd0; cmd_abort = 1'b0; data_rd = 1'b0; data_wr = 1'b0; irq_ack = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b0;
    test_reset();
    test_read_one();
    test_read_all();
    test_write();
    test_gating();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gayle_sector_xfer.md
# gayle_sector_xfer

ATA PIO data-phase sequencer for the Gayle IDE port. It sits between the CPU-side data register decode and the sector FIFO. It converts CPU data-register strokes into FIFO read and write strobes and counts words and sectors. It drives BSY, DRQ and IRQ, and asks the HPS side to fill or drain the FIFO at sector boundaries.

## Interface

Parameters:
- `WORDS_PER_SECTOR`, default 256: 16-bit words per sector; must be a power of two, max 256.

Ports:
- `clk` in 1: bus clock.
- `reset` in 1: asynchronous, active-high reset.
- `clk7_en` in 1: CPU bus qualifier; all CPU strobes are sampled only when high.
- `cmd_start` in 1: single-cycle pulse that starts a data command; ignored unless the block is in IDLE.
- `cmd_dir` in 1: sampled with `cmd_start`; 1 = read (disk→CPU), 0 = write (CPU→disk).
- `cmd_sectors` in 8: sector count, sampled with `cmd_start`; 0 means 256.
- `cmd_blk` in 5: sectors per DRQ block for READ/WRITE MULTIPLE, sampled with `cmd_start`; 0 means 1.
- `cmd_abort` in 1: forces IDLE at the next edge; has priority over everything except `reset`.
- `data_rd` in 1: CPU read of the data register (level, qualified by `clk7_en`).
- `data_wr` in 1: CPU write of the data register (level, qualified by `clk7_en`).
- `irq_ack` in 1: CPU status-register read; clears `irq`.
- `fifo_full` in 1: FIFO holds at least one sector.
- `fifo_empty` in 1: FIFO is empty.
- `fifo_rd` out 1: FIFO read strobe (combinational).
- `fifo_wr` out 1: FIFO write strobe (combinational).
- `hps_req` out 1: HPS service request; fill on reads, drain on writes.
- `bsy` out 1: ATA BSY.
- `drq` out 1: ATA DRQ.
- `irq` out 1: IDE interrupt, level.
- `xfer_active` out 1: high whenever the state is not IDLE.

## Operation

States: IDLE, R_WAIT, R_XFER, W_XFER, W_WAIT.

Counters:
- `words` is 8 bits; the sector ends when `words` == `WORDS_PER_SECTOR-1` and a stroke is accepted.
- `sect_left` is 9 bits and is loaded with 256 when `cmd_sectors` = 0.
- `blk_left` is 5 bits and is reloaded from `cmd_blk` (or 1 when `cmd_blk` = 0) at each block start.

Accepted stroke:
- Read: `clk7_en & data_rd & drq` in R_XFER.
- Write: `clk7_en & data_wr & drq` in W_XFER.
- Combinational outputs: `fifo_rd` = accepted read stroke; `fifo_wr` = accepted write stroke.
- Strokes while `drq` is low are dropped: no FIFO strobe and no counter change.

State transitions:
- **IDLE**
  - `cmd_start` with read: go to R_WAIT, `bsy`=1.
  - `cmd_start` with write: go to W_XFER, `drq`=1, `bsy`=0. No IRQ for the first write block.
- **R_WAIT**
  - `hps_req`=1 and `bsy`=1.
  - On `fifo_full`: go to R_XFER, `bsy`=0, `drq`=1.
  - If this is the first sector of a block, set `irq`.
- **R_XFER**, on the stroke that ends a sector:
  - Decrement `sect_left` and `blk_left`.
  - If `sect_left` reaches 0: go to IDLE, `drq`=0.
  - Otherwise, if `fifo_full` is still high and `blk_left` ≠ 0: stay in R_XFER.
  - Otherwise: go to R_WAIT, `drq`=0, `bsy`=1.
  - The `fifo_full` check uses the value in that cycle.
- **W_XFER**, on the stroke that ends a sector:
  - Decrement the counters.
  - If `blk_left` reaches 0 or `sect_left` reaches 0: go to W_WAIT, `drq`=0, `bsy`=1.
  - Otherwise stay in W_XFER.
- **W_WAIT**
  - `hps_req`=1.
  - On `fifo_empty`: set `irq`, `bsy`=0.
  - Then go to IDLE if `sect_left` = 0; otherwise reload `blk_left`, go to W_XFER, `drq`=1.

IRQ handling:
- `irq` is set as above and cleared by `irq_ack`.
- If set and clear coincide, set wins.
- `cmd_start` clears `irq`.

Abort:
- `cmd_abort` forces state IDLE; `drq`, `bsy` and `hps_req` go to 0.
- `irq` and the counters are left as they are.
- The FIFO is not touched; flushing it belongs to the owner of the FIFO reset.

## Timing

- Reset values: state IDLE; `drq`, `bsy`, `irq`, `hps_req`, `xfer_active` = 0; all counters = 0.
- `fifo_rd`/`fifo_wr` assert in the same cycle as the accepted stroke; zero latency.
- `drq`, `bsy`, `irq` are registered and change on the edge that samples the triggering event.
- On the last word of a sector, `drq` falls on the same edge that accepts that stroke, so a back-to-back stroke is never passed to the FIFO.
- R_WAIT→R_XFER takes 1 cycle after `fifo_full` is seen high. W_WAIT exit takes 1 cycle after `fifo_empty` is seen high.
- `hps_req` is registered and equals (state ∈ {R_WAIT, W_WAIT}) delayed by one edge.
- `cmd_start` arriving together with `cmd_abort`: abort wins and the command is dropped.

## Configuration

- `GAYLE_XFER_MULTIPLE_EN` defined: `cmd_blk` is honoured, and IRQ and block grouping follow `blk_left`.
- Not defined: `cmd_blk` is ignored and `blk_left` is fixed at 1. Every sector is its own block, with an IRQ per sector on reads and an HPS drain per sector on writes.

## Test plan

- Read, 1 sector:
  - `cmd_start`, `cmd_dir`=1, `cmd_sectors`=1 → `bsy`=1, `hps_req`=1.
  - Raise `fifo_full` → `drq`=1, `irq`=1.
  - 256 strokes → 256 `fifo_rd` pulses; `drq`=0 after the 256th; state IDLE.
- Read, `cmd_sectors`=0: verify 65536 `fifo_rd` pulses and 256 `irq` sets, with `irq_ack` after each.
- Write, 2 sectors, macro on, `cmd_blk`=2:
  - `drq`=1 immediately with no `irq`.
  - 512 strokes → `drq`=0, `bsy`=1.
  - `fifo_empty` → `irq`=1; state IDLE.
- Stroke gating:
  - `data_rd` pulses while `drq`=0 → no `fifo_rd`.
  - `clk7_en`=0 with `data_rd`=1 → no `fifo_rd`.
- Abort mid-read after 100 words → `drq`=`bsy`=`hps_req`=0 next edge; a subsequent `cmd_start` is accepted.
- Asynchronous `reset` asserted mid-W_XFER, not aligned to `clk` → all outputs 0 immediately.
